hazard_tag_pipe: RTL and testbench

Carries per-instruction hazard metadata (TNew, destination register, register-write enable, EPC-write flag) from the D stage through E, M and W, so the D-stage stall unit and the forwarding muxes always see the current producer state. Inserts a bubble into E when the stall unit asserts Stall. Flushes all in-flight tags on an exception/interrupt request. Ages TNew by one each stage advance. Also keeps a saturating count of stall cycles for performance debug.

---
 rtl/hazard_tag_pipe.sv | 114 +++++++++++
 tb/tb_hazard_tag_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tag_pipe.sv
// Hazard metadata pipeline (E/M/W) feeding the D-stage stall unit and forwarding muxes.
// Every output is a register, so Stall (derived from ETNew/MTNew) cannot form a combinational loop.
module hazard_tag_pipe (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Stall,
    input  logic        Req,
    input  logic [2:0]  DTNew,
    input  logic [4:0]  DRegDst,
    input  logic        DWriteRegEn,
    input  logic        DWriteEPC,
    output logic [2:0]  ETNew,
    output logic [2:0]  MTNew,
    output logic [2:0]  WTNew,
    output logic [4:0]  ERegDst,
    output logic [4:0]  MRegDst,
    output logic [4:0]  WRegDst,
    output logic        EWriteRegEn,
    output logic        MWriteRegEn,
    output logic        WWriteRegEn,
    output logic        EWriteEPC,
    output logic        MWriteEPC,
    output logic [15:0] StallCnt
);

    logic [2:0]  r_e_tnew, r_m_tnew, r_w_tnew;
    logic [4:0]  r_e_rd, r_m_rd, r_w_rd;
    logic        r_e_we, r_m_we, r_w_we;
    logic        r_e_epc, r_m_epc;
    logic [15:0] r_stall_cnt;

    logic        w_d_we;
    logic        w_cnt_inc;
    logic [2:0]  w_e_tnew_aged;
    logic [2:0]  w_m_tnew_aged;

    // Writes to $0 are discarded by the GPR file, so they never create a hazard.
    assign w_d_we    = DWriteRegEn && (DRegDst != 5'd0);
    assign w_cnt_inc = Stall && !Req && (r_stall_cnt != 16'hFFFF);

    // TNew counts down to zero and sticks there.
    assign w_e_tnew_aged = (r_e_tnew == 3'd0) ? 3'd0 : r_e_tnew - 3'd1;
    assign w_m_tnew_aged = (r_m_tnew == 3'd0) ? 3'd0 : r_m_tnew - 3'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_e_tnew <= 3'd0;
            r_e_rd   <= 5'd0;
            r_e_we   <= 1'b0;
            r_e_epc  <= 1'b0;
            r_m_tnew <= 3'd0;
            r_m_rd   <= 5'd0;
            r_m_we   <= 1'b0;
            r_m_epc  <= 1'b0;
            r_w_tnew <= 3'd0;
            r_w_rd   <= 5'd0;
            r_w_we   <= 1'b0;
        end else if (Req) begin
            r_e_tnew <= 3'd0;
            r_e_rd   <= 5'd0;
            r_e_we   <= 1'b0;
            r_e_epc  <= 1'b0;
            r_m_tnew <= 3'd0;
            r_m_rd   <= 5'd0;
            r_m_we   <= 1'b0;
            r_m_epc  <= 1'b0;
            r_w_tnew <= 3'd0;
            r_w_rd   <= 5'd0;
            r_w_we   <= 1'b0;
        end else begin
            r_w_tnew <= w_m_tnew_aged;
            r_w_rd   <= r_m_rd;
            r_w_we   <= r_m_we;
            r_m_tnew <= w_e_tnew_aged;
            r_m_rd   <= r_e_rd;
            r_m_we   <= r_e_we;
            r_m_epc  <= r_e_epc;
            // A stalled D instruction stays in D; E receives a bubble instead.
            if (Stall) begin
                r_e_tnew <= 3'd0;
                r_e_rd   <= 5'd0;
                r_e_we   <= 1'b0;
                r_e_epc  <= 1'b0;
            end else begin
                r_e_tnew <= DTNew;
                r_e_rd   <= DRegDst;
                r_e_we   <= w_d_we;
                r_e_epc  <= DWriteEPC;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= 16'd0;
        end else if (w_cnt_inc) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign ETNew       = r_e_tnew;
    assign MTNew       = r_m_tnew;
    assign WTNew       = r_w_tnew;
    assign ERegDst     = r_e_rd;
    assign MRegDst     = r_m_rd;
    assign WRegDst     = r_w_rd;
    assign EWriteRegEn = r_e_we;
    assign MWriteRegEn = r_m_we;
    assign WWriteRegEn = r_w_we;
    assign EWriteEPC   = r_e_epc;
    assign MWriteEPC   = r_m_epc;
    assign StallCnt    = r_stall_cnt;

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Bench for hazard_tag_pipe: directed scenarios plus random traffic against a slot-and-age model.
module tb_hazard_tag_pipe;

    logic        clk;
    logic        reset_n;
    logic        Stall;
    logic        Req;
    logic [2:0]  DTNew;
    logic [4:0]  DRegDst;
    logic        DWriteRegEn;
    logic        DWriteEPC;
    logic [2:0]  ETNew, MTNew, WTNew;
    logic [4:0]  ERegDst, MRegDst, WRegDst;
    logic        EWriteRegEn, MWriteRegEn, WWriteRegEn;
    logic        EWriteEPC, MWriteEPC;
    logic [15:0] StallCnt;

    hazard_tag_pipe dut (
        .clk(clk), .reset_n(reset_n), .Stall(Stall), .Req(Req),
        .DTNew(DTNew), .DRegDst(DRegDst), .DWriteRegEn(DWriteRegEn), .DWriteEPC(DWriteEPC),
        .ETNew(ETNew), .MTNew(MTNew), .WTNew(WTNew),
        .ERegDst(ERegDst), .MRegDst(MRegDst), .WRegDst(WRegDst),
        .EWriteRegEn(EWriteRegEn), .MWriteRegEn(MWriteRegEn), .WWriteRegEn(WWriteRegEn),
        .EWriteEPC(EWriteEPC), .MWriteEPC(MWriteEPC), .StallCnt(StallCnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each slot remembers the tag as it entered E; a stage's TNew is derived
    // from how many stages the slot has travelled (slot index), floored at zero.
    typedef struct {
        int       t0;
        bit [4:0] rd;
        bit       we;
        bit       epc;
    } slot_t;

    slot_t stg[3];
    int    exp_cnt;
    int    n_vec;
    int    n_bad;

    function automatic slot_t bubble();
        slot_t s;
        s.t0 = 0; s.rd = 0; s.we = 0; s.epc = 0;
        return s;
    endfunction

    function automatic int tnew_at(int s);
        int v;
        v = stg[s].t0 - s;
        return (v < 0) ? 0 : v;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) stg[i] = bubble();
        exp_cnt = 0;
    endtask

    task automatic model_edge();
        slot_t d;
        if (Req) begin
            for (int i = 0; i < 3; i++) stg[i] = bubble();
        end else begin
            stg[2] = stg[1];
            stg[1] = stg[0];
            if (Stall) begin
                stg[0] = bubble();
                if (exp_cnt < 65535) exp_cnt++;
            end else begin
                d.t0 = int'(DTNew);
                d.rd = DRegDst;
                d.we = DWriteRegEn && (DRegDst != 5'd0);
                d.epc = DWriteEPC;
                stg[0] = d;
            end
        end
    endtask

    task automatic check_all();
        check_val("ETNew", 32'(ETNew), 32'(tnew_at(0)));
        check_val("MTNew", 32'(MTNew), 32'(tnew_at(1)));
        check_val("WTNew", 32'(WTNew), 32'(tnew_at(2)));
        check_val("ERegDst", 32'(ERegDst), 32'(stg[0].rd));
        check_val("MRegDst", 32'(MRegDst), 32'(stg[1].rd));
        check_val("WRegDst", 32'(WRegDst), 32'(stg[2].rd));
        check_val("EWe", 32'(EWriteRegEn), 32'(stg[0].we));
        check_val("MWe", 32'(MWriteRegEn), 32'(stg[1].we));
        check_val("WWe", 32'(WWriteRegEn), 32'(stg[2].we));
        check_val("EEpc", 32'(EWriteEPC), 32'(stg[0].epc));
        check_val("MEpc", 32'(MWriteEPC), 32'(stg[1].epc));
        check_val("StallCnt", 32'(StallCnt), 32'(exp_cnt));
    endtask

    // driver tasks
    task automatic drive(input logic st, input logic rq, input int t, input int rd,
                         input logic we, input logic epc);
        Stall = st; Req = rq;
        DTNew = 3'(t); DRegDst = 5'(rd); DWriteRegEn = we; DWriteEPC = epc;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        reset_n = 1'b1;
    endtask

    logic [15:0] cnt_before;

    initial begin
        n_vec = 0; n_bad = 0;
        model_reset();
        reset_n = 1'b0;
        // reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
            @(negedge clk);
            check_all();
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // single tag through the pipe
        drive(0, 0, 2, 5, 1, 0);
        cycle();
        check_val("rst_E_tnew", 32'(ETNew), 2);
        check_val("rst_E_rd", 32'(ERegDst), 5);
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        check_val("rst_M_tnew", 32'(MTNew), 1);
        check_val("rst_M_we", 32'(MWriteRegEn), 1);
        cycle();
        check_val("rst_W_tnew", 32'(WTNew), 0);
        check_val("rst_W_rd", 32'(WRegDst), 5);

        // $0 destination filter
        drive(0, 0, 3, 0, 1, 0);
        cycle();
        check_val("zero_E_we", 32'(EWriteRegEn), 0);

        // stall bubble
        drive(0, 0, 2, 7, 1, 0);
        cycle();
        cnt_before = StallCnt;
        drive(1, 0, 1, 8, 1, 0);
        cycle();
        check_val("stall_M_rd", 32'(MRegDst), 7);
        check_val("stall_E_we", 32'(EWriteRegEn), 0);
        cycle();
        drive(0, 0, 1, 8, 1, 0);
        cycle();
        check_val("stall_E_rd", 32'(ERegDst), 8);
        check_val("stall_cnt", 32'(StallCnt - cnt_before), 2);

        // TNew saturation
        drive(0, 0, 0, 9, 1, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        check_val("sat_W_tnew", 32'(WTNew), 0);

        // flush priority with EPC write in flight
        drive(0, 0, 4, 3, 1, 1);
        cycle();
        drive(0, 0, 3, 4, 1, 0);
        cycle();
        drive(0, 0, 5, 6, 1, 1);
        cycle();
        check_val("flush_pre_epc", 32'(EWriteEPC), 1);
        cnt_before = StallCnt;
        drive(1, 1, 7, 10, 1, 1);
        cycle();
        check_val("flush_cnt", 32'(StallCnt), 32'(cnt_before));
        check_val("flush_W_we", 32'(WWriteRegEn), 0);

        // random traffic with occasional asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                  1'($urandom), 1'($urandom));
            if ($urandom_range(0, 499) == 0) async_reset();
            else cycle();
        end

        // counter saturation
        async_reset();
        drive(1, 0, 3, 12, 1, 0);
        for (int i = 0; i < 65540; i++) cycle();
        check_val("cnt_sat", 32'(StallCnt), 32'hFFFF);
        drive(0, 0, 3, 12, 1, 0);
        cycle();
        check_val("cnt_hold", 32'(StallCnt), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
